// File: rtl/pipe_ctrl.sv
// Pipeline control: stall merging, exception/ERET flush and redirect, deferred flush while
// AXI buses drain. Optional stall watchdog enabled by defining PIPE_CTRL_WDOG_EN.
module pipe_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
  parameter int unsigned WDOG_LIMIT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype,
  input  logic [31:0] cp0_epc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic [31:0] stall_cycles,
  output logic        wdog_timeout
);

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  localparam logic [31:0] ExcEret = 32'h0000000E;
  localparam logic [5:0]  StallAll = 6'b111111;

  state_e      state_q, state_d;
  logic [31:0] exc_q, exc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] stall_cycles_q;
  logic [5:0]  prio_stall;
  logic        bus_busy;

  assign bus_busy = stallreq_if | stallreq_mem;

  always_comb begin
    prio_stall = 6'b000000;
    if (stallreq_mem)     prio_stall = 6'b011111;
    else if (stallreq_ex) prio_stall = 6'b001111;
    else if (stallreq_id) prio_stall = 6'b000111;
    else if (stallreq_if) prio_stall = 6'b000011;
  end

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    epc_d   = epc_q;
    stall   = 6'b000000;
    flush   = 1'b0;
    new_pc  = EXC_VECTOR;
    unique case (state_q)
      StRun: begin
        new_pc = (excepttype == ExcEret) ? cp0_epc : EXC_VECTOR;
        if (excepttype != 32'd0) begin
          if (!bus_busy) begin
            flush = 1'b1;
          end else begin
            // Hold everything until in-flight bus transfers complete.
            exc_d   = excepttype;
            epc_d   = cp0_epc;
            stall   = StallAll;
            state_d = StDrain;
          end
        end else begin
          stall = prio_stall;
        end
      end
      StDrain: begin
        new_pc = (exc_q == ExcEret) ? epc_q : EXC_VECTOR;
        if (bus_busy) begin
          stall = StallAll;
        end else begin
          flush   = 1'b1;
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase
    if (rst) begin
      stall  = 6'b000000;
      flush  = 1'b0;
      new_pc = EXC_VECTOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StRun;
      exc_q          <= '0;
      epc_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      epc_q   <= epc_d;
      if (stall != 6'b000000) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;

  localparam logic [15:0] WdogMax = 16'(WDOG_LIMIT);

`ifdef PIPE_CTRL_WDOG_EN
  logic [15:0] wdog_cnt_q, wdog_cnt_d;
  logic        wdog_q;

  always_comb begin
    wdog_cnt_d = wdog_cnt_q;
    if (stall == 6'b000000)        wdog_cnt_d = '0;
    else if (wdog_cnt_q < WdogMax) wdog_cnt_d = wdog_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_cnt_q <= '0;
      wdog_q     <= 1'b0;
    end else begin
      wdog_cnt_q <= wdog_cnt_d;
      if (wdog_cnt_d == WdogMax) wdog_q <= 1'b1;
    end
  end

  assign wdog_timeout = wdog_q;
`else
  logic unused_wdog_limit;
  assign unused_wdog_limit = ^WdogMax;
  assign wdog_timeout      = 1'b0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control unit for the five-stage MIPS core. It merges per-stage stall requests into the 6-bit `stall` vector consumed by every pipeline register, including the IF/ID register. It also generates the one-cycle `flush` and redirect `new_pc` on exceptions and ERET. Exceptions raised while an AXI instruction or data transaction is in flight are deferred until both buses drain, so no outstanding bus transfer is orphaned.

## Interface
Parameters:
- `EXC_VECTOR`, default 32'hBFC00380: general exception entry address.
- `WDOG_LIMIT`, default 1023: consecutive-stall limit for the watchdog (see Configuration).

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset, synchronous, active-high
- `stallreq_if`  in  1  instruction bus busy (AXI fetch outstanding)
- `stallreq_id`  in  1  load-use hazard
- `stallreq_ex`  in  1  multi-cycle EX op (div) busy
- `stallreq_mem`  in  1  data bus busy (AXI load/store outstanding)
- `excepttype`  in  32  MEM-stage exception code; 0 = none, 32'h0000000E = ERET
- `cp0_epc`  in  32  current EPC
- `stall`  out  6  bit0 PC, 1 IF, 2 ID, 3 EX, 4 MEM, 5 WB; 1 = hold
- `flush`  out  1  clear all pipeline registers this cycle
- `new_pc`  out  32  redirect target, valid when `flush`=1
- `stall_cycles`  out  32  count of cycles with `stall`!=0
- `wdog_timeout`  out  1  sticky watchdog flag (only with macro)

## Operation
- Stall priority, highest first; the first matching request selects `stall`:
  - `stallreq_mem`: 6'b011111
  - `stallreq_ex`: 6'b001111
  - `stallreq_id`: 6'b000111
  - `stallreq_if`: 6'b000011
  - none: 6'b000000
- The pattern `stall[1]`=1, `stall[2]`=0 makes IF/ID insert a bubble.
- Redirect target: `new_pc` = `cp0_epc` if the exception code is 32'h0000000E, else `EXC_VECTOR`.
- FSM states:
  - S_RUN:
    - If `excepttype`!=0 and `stallreq_if`=`stallreq_mem`=0: `flush`=1 and `stall`=0 this cycle (combinational); stay in S_RUN.
    - If `excepttype`!=0 and either bus is busy: latch `excepttype` and `cp0_epc` into `exc_q` and `epc_q`; `stall`=6'b111111; `flush`=0; go to S_DRAIN.
    - Otherwise: `flush`=0; apply the stall priority.
  - S_DRAIN:
    - `stall`=6'b111111 while either bus is busy.
    - In the first cycle both bus requests are 0: `flush`=1, `stall`=0, `new_pc` derived from `exc_q`/`epc_q`; go to S_RUN.
    - Live `excepttype` is ignored in this state.
- `stallreq_id` and `stallreq_ex` never block a flush; the flush kills those instructions.
- `stall_cycles`:
  - Increments by 1 at each posedge where `stall`!=0, including S_DRAIN cycles.
  - Wraps from 32'hFFFFFFFF to 0.
- Reset: state S_RUN; `exc_q`, `epc_q`, `stall_cycles` = 0; `wdog_timeout` = 0.
  - Consequently `stall`=0, `flush`=0, `new_pc`=`EXC_VECTOR` while `rst`=1.
  - Reset asserted during S_DRAIN drops the pending exception.
- While `rst`=1, `stall` and `flush` are forced to 0 regardless of inputs.

## Timing
- `stall`, `flush`, `new_pc` are combinational from inputs and state; they take effect at the same posedge that samples them.
- Exception with idle buses: 0-cycle latency; flush in the cycle `excepttype` first goes nonzero.
- Deferred exception: flush in cycle N, where N is the first cycle with both bus requests low after entry to S_DRAIN. Minimum N = entry+1.
- `flush` is never high for two consecutive cycles from a single exception.

## Configuration
- `PIPE_CTRL_WDOG_EN`:
  - Defined:
    - A 16-bit counter increments each cycle `stall`!=0 and clears whenever `stall`=0.
    - When the counter reaches `WDOG_LIMIT`, `wdog_timeout` sets and stays set until `rst`.
    - The counter saturates at `WDOG_LIMIT`.
  - Undefined: counter logic is absent and `wdog_timeout` is tied to 0.

## Test plan
- `stallreq_mem`=1 and `stallreq_id`=1 together -> `stall`=6'b011111; only `stallreq_if`=1 -> 6'b000011; `stall_cycles` advances by 2 over those two cycles.
- `excepttype`=32'h00000001 with buses idle -> same cycle `flush`=1, `new_pc`=32'hBFC00380, `stall`=0.
- `excepttype`=32'h0000000E, `cp0_epc`=32'hBFC01000, `stallreq_mem`=1 for 3 cycles -> `stall`=6'b111111 for 3 cycles. Then exactly one cycle of `flush`=1 with `new_pc`=32'hBFC01000, even though `excepttype` and `cp0_epc` change during the drain.
- `rst` asserted in S_DRAIN -> next cycle `flush`=0, `stall`=0, `stall_cycles`=0; no flush after `rst` deasserts.
- With `PIPE_CTRL_WDOG_EN` and `WDOG_LIMIT`=4: `stallreq_ex` held 4 cycles -> `wdog_timeout`=1 after the 4th stalled cycle and stays 1 after `stallreq_ex` drops. Holding only 3 cycles, then 1 free cycle, then 3 more -> `wdog_timeout` stays 0.
- `stall_cycles` preloaded near wrap (force to 32'hFFFFFFFF) plus one stall cycle -> `stall_cycles`=0.
